// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU instruction sequencer: opcode values,
// counter width and the control state encoding.
package alu_ctrl_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_AND2 = 5'b01100;
  localparam logic [4:0] OP_OR2  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;

  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T3   = 3'd1,
    ST_T4   = 3'd2,
    ST_T5   = 3'd3,
    ST_T6   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction request and datapath strobe bundle between an issuer and
// the ALU sequencer.
interface alu_sequencer_if;
  logic       start;
  logic [4:0] opcode;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       busy;
  logic       done;
  logic       illegal;
  logic [3:0] reg_sel;
  logic       reg_out;
  logic       reg_in;
  logic       y_in;
  logic       z_in;
  logic       zlo_out;
  logic       zhi_out;
  logic       lo_in;
  logic       hi_in;
  logic [4:0] alu_opcode;

  modport master (
    output start, opcode, ra, rb, rc,
    input  busy, done, illegal, reg_sel, reg_out, reg_in, y_in, z_in,
           zlo_out, zhi_out, lo_in, hi_in, alu_opcode
  );

  modport slave (
    input  start, opcode, ra, rb, rc,
    output busy, done, illegal, reg_sel, reg_out, reg_in, y_in, z_in,
           zlo_out, zhi_out, lo_in, hi_in, alu_opcode
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode classifier: legality, unary (single source) and
// multi-cycle multiply/divide.
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output logic       legal,
  output logic       is_unary,
  output logic       is_muldiv
);

  // Classify the opcode into the three control attributes.
  always_comb begin
    legal     = 1'b0;
    is_unary  = 1'b0;
    is_muldiv = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
      OP_AND, OP_OR, OP_AND2, OP_OR2: begin
        legal = 1'b1;
      end
      OP_MUL, OP_DIV: begin
        legal     = 1'b1;
        is_muldiv = 1'b1;
      end
      OP_NEG, OP_NOT: begin
        legal    = 1'b1;
        is_unary = 1'b1;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// ALU instruction sequencer: steps one accepted instruction through the
// T3..T6 control phases, holding T4 for MD_CYCLES cycles on mul/div.
// All outputs are registered Moore outputs decoded from the next state,
// so they line up with the state they describe.
module alu_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned MD_CYCLES = 4
)
(
  input  logic            clk,
  input  logic            clr,
  alu_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] MD_LAST = CNT_W'(MD_CYCLES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       op_q, op_d;
  logic [3:0]       ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic             unary_q, unary_d;
  logic             muldiv_q, muldiv_d;
  logic             ill_q, ill_d;
  logic             z_fire;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;
  logic [3:0]       reg_sel_q, reg_sel_d;
  logic             reg_out_q, reg_out_d;
  logic             reg_in_q, reg_in_d;
  logic             y_in_q, y_in_d;
  logic             z_in_q, z_in_d;
  logic             zlo_out_q, zlo_out_d;
  logic             zhi_out_q, zhi_out_d;
  logic             lo_in_q, lo_in_d;
  logic             hi_in_q, hi_in_d;
  logic [4:0]       alu_opcode_q, alu_opcode_d;

  logic             dec_legal, dec_unary, dec_muldiv;

  alu_op_decode u_decode (
    .opcode    (bus.opcode),
    .legal     (dec_legal),
    .is_unary  (dec_unary),
    .is_muldiv (dec_muldiv)
  );

  // Next-state, latched-field and next-output computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rc_d     = rc_q;
    unary_d  = unary_q;
    muldiv_d = muldiv_q;
    ill_d    = ill_q;
    z_fire   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d     = bus.opcode;
          ra_d     = bus.ra;
          rb_d     = bus.rb;
          rc_d     = bus.rc;
          unary_d  = dec_unary;
          muldiv_d = dec_muldiv;
          ill_d    = !dec_legal;
          cnt_d    = '0;
          state_d  = dec_legal ? ST_T3 : ST_DONE;
        end
      end
      ST_T3: begin
        // cnt counts T4 cycles including the one being entered.
        state_d = ST_T4;
        cnt_d   = CNT_W'(1);
        z_fire  = !muldiv_q || (MD_LAST == CNT_W'(1));
      end
      ST_T4: begin
        if (muldiv_q && (cnt_q != MD_LAST)) begin
          cnt_d  = cnt_q + CNT_W'(1);
          z_fire = ((cnt_q + CNT_W'(1)) == MD_LAST);
        end else begin
          cnt_d   = '0;
          state_d = ST_T5;
        end
      end
      ST_T5: begin
        state_d = muldiv_q ? ST_T6 : ST_DONE;
      end
      ST_T6: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d       = (state_d != ST_IDLE);
    done_d       = 1'b0;
    illegal_d    = 1'b0;
    reg_sel_d    = '0;
    reg_out_d    = 1'b0;
    reg_in_d     = 1'b0;
    y_in_d       = 1'b0;
    z_in_d       = 1'b0;
    zlo_out_d    = 1'b0;
    zhi_out_d    = 1'b0;
    lo_in_d      = 1'b0;
    hi_in_d      = 1'b0;
    alu_opcode_d = '0;

    case (state_d)
      ST_T3: begin
        reg_sel_d = rb_d;
        reg_out_d = 1'b1;
        y_in_d    = 1'b1;
      end
      ST_T4: begin
        alu_opcode_d = op_d;
        z_in_d       = z_fire;
        if (!unary_d) begin
          reg_sel_d = rc_d;
          reg_out_d = 1'b1;
        end
      end
      ST_T5: begin
        zlo_out_d = 1'b1;
        if (muldiv_d) begin
          lo_in_d = 1'b1;
        end else begin
          reg_sel_d = ra_d;
          reg_in_d  = 1'b1;
        end
      end
      ST_T6: begin
        zhi_out_d = 1'b1;
        hi_in_d   = 1'b1;
      end
      ST_DONE: begin
        done_d    = 1'b1;
        illegal_d = ill_d;
      end
      default: begin
        busy_d = busy_d;
      end
    endcase
  end

  // State, counter, latched fields and registered outputs; clr wins over start.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      ra_q         <= '0;
      rb_q         <= '0;
      rc_q         <= '0;
      unary_q      <= 1'b0;
      muldiv_q     <= 1'b0;
      ill_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      reg_sel_q    <= '0;
      reg_out_q    <= 1'b0;
      reg_in_q     <= 1'b0;
      y_in_q       <= 1'b0;
      z_in_q       <= 1'b0;
      zlo_out_q    <= 1'b0;
      zhi_out_q    <= 1'b0;
      lo_in_q      <= 1'b0;
      hi_in_q      <= 1'b0;
      alu_opcode_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      ra_q         <= ra_d;
      rb_q         <= rb_d;
      rc_q         <= rc_d;
      unary_q      <= unary_d;
      muldiv_q     <= muldiv_d;
      ill_q        <= ill_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      illegal_q    <= illegal_d;
      reg_sel_q    <= reg_sel_d;
      reg_out_q    <= reg_out_d;
      reg_in_q     <= reg_in_d;
      y_in_q       <= y_in_d;
      z_in_q       <= z_in_d;
      zlo_out_q    <= zlo_out_d;
      zhi_out_q    <= zhi_out_d;
      lo_in_q      <= lo_in_d;
      hi_in_q      <= hi_in_d;
      alu_opcode_q <= alu_opcode_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.illegal    = illegal_q;
  assign bus.reg_sel    = reg_sel_q;
  assign bus.reg_out    = reg_out_q;
  assign bus.reg_in     = reg_in_q;
  assign bus.y_in       = y_in_q;
  assign bus.z_in       = z_in_q;
  assign bus.zlo_out    = zlo_out_q;
  assign bus.zhi_out    = zhi_out_q;
  assign bus.lo_in      = lo_in_q;
  assign bus.hi_in      = hi_in_q;
  assign bus.alu_opcode = alu_opcode_q;

endmodule
